mem_port_arbiter: RTL and testbench

Shares the single SRAM-style memory port between the instruction-fetch requester and the memory-stage data requester (loads and stores).
- Serialises requests; one transaction is outstanding at a time.
- Returns read data to the owning requester.
- Generates the pipeline stall signal inst_wait, which freezes the memory-stage and upstream pipeline registers.
- Drives the abort-discard handling for cancelled fetches.

---
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and load/store requests onto one SRAM-style port.
// Optional macro ARB_ROUND_ROBIN_EN alternates priority when both requesters tie in IDLE.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_done,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [3:0]        d_wstrb,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   input  logic              abort,
   output logic              inst_wait,
   output logic              m_req,
   output logic              m_wr,
   output logic [ADDR_W-1:0] m_addr,
   output logic [3:0]        m_wstrb,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_addr_ok,
   input  logic              m_data_ok,
   input  logic [DATA_W-1:0] m_rdata
);

   typedef enum logic [2:0] {IDLE, D_ADDR, D_DATA, I_ADDR, I_DATA} state_t;

   localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

   state_t state;
   state_t state_next;
   logic   d_want;
   logic   i_want;
   logic   grant_d;
   logic   grant_i;
   logic   abort_flag;
   logic   i_ret;

   // A requester whose done pulse is showing this cycle is not asking for a new transfer yet.
   assign d_want    = d_req && !d_done;
   assign i_want    = i_req && !i_done && !abort;
   assign inst_wait = (i_req && !i_done) || (d_req && !d_done);
   assign m_req     = (state == D_ADDR) || (state == I_ADDR);

`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant_d;

   always_ff @(posedge clk) begin
      if (rst)
         last_grant_d <= 1'b1;
      else if (grant_d)
         last_grant_d <= 1'b1;
      else if (grant_i)
         last_grant_d <= 1'b0;
   end

   always_comb begin
      grant_d = 1'b0;
      grant_i = 1'b0;
      if (state == IDLE) begin
         if (d_want && i_want) begin
            grant_i = last_grant_d;
            grant_d = !last_grant_d;
         end else begin
            grant_d = d_want;
            grant_i = i_want;
         end
      end
   end
`else
   assign grant_d = (state == IDLE) && d_want;
   assign grant_i = (state == IDLE) && i_want && !d_want;
`endif

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (grant_d)
               state_next = D_ADDR;
            else if (grant_i)
               state_next = I_ADDR;
         end
         D_ADDR: if (m_addr_ok) state_next = D_DATA;
         D_DATA: if (m_data_ok) state_next = IDLE;
         I_ADDR: begin
            if (m_addr_ok)
               state_next = I_DATA;
            else if (abort)
               state_next = IDLE;
         end
         I_DATA: if (m_data_ok) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // A fetch cancelled after acceptance still drains the port but never reports done.
   assign i_ret = (state == I_DATA) && m_data_ok && !abort_flag && !abort;

   always_ff @(posedge clk) begin
      if (rst) begin
         m_wr       <= 1'b0;
         m_addr     <= '0;
         m_wstrb    <= 4'b0000;
         m_wdata    <= '0;
         i_done     <= 1'b0;
         d_done     <= 1'b0;
         i_rdata    <= '0;
         d_rdata    <= '0;
         abort_flag <= 1'b0;
      end else begin
         i_done <= i_ret;
         d_done <= (state == D_DATA) && m_data_ok;
         if (grant_d) begin
            m_wr    <= d_wr;
            m_addr  <= d_addr & WORD_MASK;
            m_wstrb <= d_wr ? d_wstrb : 4'b0000;
            m_wdata <= d_wdata;
         end else if (grant_i) begin
            m_wr    <= 1'b0;
            m_addr  <= i_addr & WORD_MASK;
            m_wstrb <= 4'b0000;
            m_wdata <= '0;
         end
         if (i_ret)
            i_rdata <= m_rdata;
         if ((state == D_DATA) && m_data_ok)
            d_rdata <= m_rdata;
         if (state_next == IDLE)
            abort_flag <= 1'b0;
         else if (abort && ((state == I_DATA) || ((state == I_ADDR) && m_addr_ok)))
            abort_flag <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks against a memory reference model.
// Build with ARB_ROUND_ROBIN_EN defined to check the alternating-priority variant.
module tb_mem_port_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              i_req, d_req, d_wr, abort;
   logic [ADDR_W-1:0] i_addr, d_addr;
   logic [3:0]        d_wstrb;
   logic [DATA_W-1:0] d_wdata;
   logic              i_done, d_done, inst_wait;
   logic [DATA_W-1:0] i_rdata, d_rdata;
   logic              m_req, m_wr, m_addr_ok, m_data_ok;
   logic [ADDR_W-1:0] m_addr;
   logic [3:0]        m_wstrb;
   logic [DATA_W-1:0] m_wdata, m_rdata;

   int testsRun = 0;
   int testsFailed = 0;
   int iDoneSeen = 0, dDoneSeen = 0, iDoneExpect = 0, dDoneExpect = 0;

   // current request contents, as the requesters issued them
   logic [31:0] curIAddr = 0, curDAddr = 0, curDWdata = 0;
   logic        curDWr = 0;
   logic [3:0]  curDStrb = 0;

   // port environment controls: delay < 0 means random 0..3 cycles
   int  cfgAddrDelay = 0, cfgDataDelay = 0;
   bit  portManual = 0, manualAddrOk = 0, manualDataOk = 0;
   bit  portBusy = 0, portArmed = 0;
   int  addrWait = 0, dataWait = 0;
   logic [31:0] pAddr, pWdata;
   logic        pWr;
   logic [3:0]  pStrb;

   logic [31:0] portMem [logic [29:0]];
   logic [31:0] refMem  [logic [29:0]];
   logic [31:0] portLog [$];

   bit prevMReq = 0, prevPendD = 0, prevPendI = 0, lastGrantData = 1;
   bit isFetch, expFetch;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata),
      .abort(abort), .inst_wait(inst_wait),
      .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wstrb(m_wstrb), .m_wdata(m_wdata),
      .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   function automatic logic [31:0] defaultWord(input logic [31:0] a);
      return {a[31:2], 2'b00} ^ 32'h5A5A_5A5A;
   endfunction

   function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] refRead(input logic [31:0] a);
      return refMem.exists(a[31:2]) ? refMem[a[31:2]] : defaultWord(a);
   endfunction

   function automatic logic [31:0] portRead(input logic [31:0] a);
      return portMem.exists(a[31:2]) ? portMem[a[31:2]] : defaultWord(a);
   endfunction

   function automatic int pickDelay(input int cfg);
      return (cfg < 0) ? int'($urandom_range(0, 3)) : cfg;
   endfunction

   task automatic preload(input logic [31:0] a, input logic [31:0] v);
      portMem[a[31:2]] = v;
      refMem[a[31:2]] = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // SRAM-style port: address handshake after a delay, then data/ack after another
   initial begin
      m_addr_ok = 0;
      m_data_ok = 0;
      m_rdata = 0;
      forever begin
         @(posedge clk);
         #2;
         if (portManual) begin
            m_addr_ok = manualAddrOk;
            m_data_ok = manualDataOk;
            portBusy = 0;
            portArmed = 0;
         end else begin
            m_addr_ok = 0;
            m_data_ok = 0;
            if (portBusy) begin
               if (dataWait == 0) begin
                  m_data_ok = 1;
                  m_rdata = pWr ? 32'h0 : portRead(pAddr);
                  if (pWr) portMem[pAddr[31:2]] = mergeBytes(portRead(pAddr), pWdata, pStrb);
                  portBusy = 0;
               end else dataWait--;
            end else if (m_req) begin
               if (!portArmed) begin
                  addrWait = pickDelay(cfgAddrDelay);
                  portArmed = 1;
               end
               if (addrWait == 0) begin
                  m_addr_ok = 1;
                  pAddr = m_addr; pWr = m_wr; pStrb = m_wstrb; pWdata = m_wdata;
                  portArmed = 0;
                  portBusy = 1;
                  dataWait = pickDelay(cfgDataDelay);
               end else addrWait--;
            end else portArmed = 0;
         end
      end
   end

   // Monitor: done counts, port fields vs. issued requests, grant order
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            lastGrantData = 1;
            prevMReq = 0; prevPendD = 0; prevPendI = 0;
         end else begin
            if (i_done) iDoneSeen++;
            if (d_done) dDoneSeen++;
            if (m_req) begin
               isFetch = (m_addr[31:28] == 4'hB);
               if (!prevMReq) begin
                  portLog.push_back(m_addr);
                  if (prevPendD && prevPendI) expFetch = RR ? lastGrantData : 1'b0;
                  else expFetch = prevPendI;
                  checkOutput("grant_owner", 32'(isFetch), 32'(expFetch));
                  lastGrantData = !isFetch;
               end
               if (isFetch) begin
                  checkOutput("m_addr_fetch", m_addr, {curIAddr[31:2], 2'b00});
                  checkOutput("m_wr_fetch", 32'(m_wr), 32'd0);
                  checkOutput("m_wstrb_fetch", 32'(m_wstrb), 32'd0);
               end else begin
                  checkOutput("m_addr_data", m_addr, {curDAddr[31:2], 2'b00});
                  checkOutput("m_wr_data", 32'(m_wr), 32'(curDWr));
                  checkOutput("m_wstrb_data", 32'(m_wstrb), curDWr ? 32'(curDStrb) : 32'd0);
                  if (curDWr) checkOutput("m_wdata_data", m_wdata, curDWdata);
               end
            end
            prevMReq = m_req;
            prevPendD = d_req && !d_done;
            prevPendI = i_req && !i_done && !abort;
         end
      end
   end

   task automatic issueFetch(input logic [31:0] a);
      bit got;
      tick();
      curIAddr = a; i_addr = a; i_req = 1;
      got = 0;
      for (int n = 0; n < 300 && !got; n++) begin
         @(negedge clk);
         if (i_done) got = 1;
      end
      checkOutput("i_done_timeout", 32'(got), 32'd1);
      if (got) begin
         checkOutput("i_rdata", i_rdata, refRead(a));
         iDoneExpect++;
      end
      tick();
      i_req = 0;
   endtask

   task automatic issueData(input logic wr, input logic [31:0] a, input logic [3:0] strb, input logic [31:0] wd);
      bit got;
      tick();
      curDAddr = a; curDWr = wr; curDStrb = strb; curDWdata = wd;
      d_addr = a; d_wr = wr; d_wstrb = strb; d_wdata = wd; d_req = 1;
      got = 0;
      for (int n = 0; n < 300 && !got; n++) begin
         @(negedge clk);
         if (d_done) got = 1;
      end
      checkOutput("d_done_timeout", 32'(got), 32'd1);
      if (got) begin
         if (wr) refMem[a[31:2]] = mergeBytes(refRead(a), wd, strb);
         else checkOutput("d_rdata", d_rdata, refRead(a));
         dDoneExpect++;
      end
      tick();
      d_req = 0;
   endtask

   task automatic applyStimulus(input int count);
      fork
         begin
            repeat (count) begin
               repeat ($urandom_range(0, 3)) tick();
               issueFetch(32'hBFC0_0000 + 32'($urandom_range(0, 15)) * 4);
            end
         end
         begin
            repeat (count) begin
               repeat ($urandom_range(0, 3)) tick();
               issueData(1'($urandom_range(0, 1)), 32'h8000_0000 + 32'($urandom_range(0, 63)),
                         4'($urandom_range(1, 15)), $urandom);
            end
         end
      join
   endtask

   initial begin
      rst = 1; i_req = 0; d_req = 0; d_wr = 0; abort = 0;
      i_addr = 0; d_addr = 0; d_wstrb = 0; d_wdata = 0;

      // reset held two cycles
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      checkOutput("rst_m_req", 32'(m_req), 0);
      checkOutput("rst_m_wr", 32'(m_wr), 0);
      checkOutput("rst_m_addr", m_addr, 0);
      checkOutput("rst_m_wstrb", 32'(m_wstrb), 0);
      checkOutput("rst_m_wdata", m_wdata, 0);
      checkOutput("rst_i_done", 32'(i_done), 0);
      checkOutput("rst_d_done", 32'(d_done), 0);
      checkOutput("rst_i_rdata", i_rdata, 0);
      checkOutput("rst_d_rdata", d_rdata, 0);
      checkOutput("rst_inst_wait", 32'(inst_wait), 0);

      // zero-wait fetch latency
      preload(32'hBFC0_0004, 32'h2408_0001);
      tick();
      curIAddr = 32'hBFC0_0004; i_addr = curIAddr; i_req = 1;
      @(negedge clk);
      checkOutput("f_c0_wait", 32'(inst_wait), 1);
      checkOutput("f_c0_m_req", 32'(m_req), 0);
      tick(); @(negedge clk);
      checkOutput("f_c1_m_req", 32'(m_req), 1);
      checkOutput("f_c1_m_addr", m_addr, 32'hBFC0_0004);
      checkOutput("f_c1_wait", 32'(inst_wait), 1);
      tick(); @(negedge clk);
      checkOutput("f_c2_m_req", 32'(m_req), 0);
      checkOutput("f_c2_i_done", 32'(i_done), 0);
      checkOutput("f_c2_wait", 32'(inst_wait), 1);
      tick(); @(negedge clk);
      checkOutput("f_c3_i_done", 32'(i_done), 1);
      checkOutput("f_c3_i_rdata", i_rdata, 32'h2408_0001);
      checkOutput("f_c3_wait", 32'(inst_wait), 0);
      iDoneExpect++;
      tick(); i_req = 0;
      @(negedge clk);
      checkOutput("f_c4_i_done", 32'(i_done), 0);

      // unaligned store, address accepted after two wait cycles
      cfgAddrDelay = 2;
      tick();
      curDAddr = 32'h8000_1003; curDWr = 1; curDStrb = 4'b1000; curDWdata = 32'hAA00_0000;
      d_addr = curDAddr; d_wr = 1; d_wstrb = curDStrb; d_wdata = curDWdata; d_req = 1;
      @(negedge clk);
      checkOutput("s_c0_m_req", 32'(m_req), 0);
      for (int c = 1; c <= 3; c++) begin
         tick(); @(negedge clk);
         checkOutput("s_m_req_held", 32'(m_req), 1);
         checkOutput("s_m_addr", m_addr, 32'h8000_1000);
         checkOutput("s_m_wr", 32'(m_wr), 1);
         checkOutput("s_m_wstrb", 32'(m_wstrb), 32'h8);
         checkOutput("s_m_wdata", m_wdata, 32'hAA00_0000);
      end
      tick(); @(negedge clk);
      checkOutput("s_c4_m_req", 32'(m_req), 0);
      checkOutput("s_c4_d_done", 32'(d_done), 0);
      tick(); @(negedge clk);
      checkOutput("s_c5_d_done", 32'(d_done), 1);
      refMem[30'h2000_0400] = mergeBytes(refRead(32'h8000_1000), 32'hAA00_0000, 4'b1000);
      dDoneExpect++;
      tick(); d_req = 0;
      @(negedge clk);
      checkOutput("s_c6_d_done", 32'(d_done), 0);
      cfgAddrDelay = 0;

      // simultaneous fetch and load
      portLog.delete();
      fork
         issueFetch(32'hBFC0_0100);
         issueData(1'b0, 32'h8000_0010, 4'h0, 32'h0);
      join
      checkOutput("tie_count", 32'(portLog.size()), 2);
      if (portLog.size() == 2) begin
         checkOutput("tie_first", portLog[0], RR ? 32'hBFC0_0100 : 32'h8000_0010);
         checkOutput("tie_second", portLog[1], RR ? 32'h8000_0010 : 32'hBFC0_0100);
      end

      // abort while fetch data is outstanding
      cfgDataDelay = 2;
      tick();
      curIAddr = 32'hBFC0_0200; i_addr = curIAddr; i_req = 1;
      tick();
      tick(); abort = 1; i_req = 0;
      @(negedge clk);
      checkOutput("ab_data_m_req", 32'(m_req), 0);
      tick(); abort = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput("ab_data_i_done", 32'(i_done), 0);
         checkOutput("ab_data_m_req", 32'(m_req), 0);
         tick();
      end
      cfgDataDelay = 0;
      issueFetch(32'hBFC0_0200);

      // abort before the port accepts the fetch address
      cfgAddrDelay = 3;
      tick();
      curIAddr = 32'hBFC0_0300; i_addr = curIAddr; i_req = 1;
      tick(); @(negedge clk);
      checkOutput("ab_addr_m_req", 32'(m_req), 1);
      tick(); abort = 1; i_req = 0;
      tick(); abort = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checkOutput("ab_addr_idle", 32'(m_req), 0);
         checkOutput("ab_addr_i_done", 32'(i_done), 0);
         tick();
      end
      cfgAddrDelay = 0;

      // abort in IDLE blocks the fetch from starting
      i_req = 1; abort = 1; curIAddr = 32'hBFC0_0400; i_addr = curIAddr;
      tick(); i_req = 0; abort = 0;
      @(negedge clk);
      checkOutput("ab_idle_m_req", 32'(m_req), 0);

      // reset during D_DATA, stray data_ok after release
      portManual = 1;
      tick();
      curDAddr = 32'h8000_0020; curDWr = 0; curDStrb = 0; curDWdata = 0;
      d_addr = curDAddr; d_wr = 0; d_wstrb = 0; d_wdata = 0; d_req = 1;
      tick(); manualAddrOk = 1;
      @(negedge clk);
      checkOutput("rm_m_req", 32'(m_req), 1);
      tick(); manualAddrOk = 0; rst = 1; d_req = 0;
      tick(); rst = 0; manualDataOk = 1;
      @(negedge clk);
      checkOutput("rm_m_addr", m_addr, 0);
      checkOutput("rm_m_req_idle", 32'(m_req), 0);
      tick(); manualDataOk = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput("rm_d_done", 32'(d_done), 0);
         checkOutput("rm_d_rdata", d_rdata, 0);
         checkOutput("rm_m_req", 32'(m_req), 0);
         tick();
      end
      portManual = 0;
      issueData(1'b0, 32'h8000_1002, 4'h0, 32'h0);

      // randomized traffic with random port delays
      cfgAddrDelay = -1;
      cfgDataDelay = -1;
      applyStimulus(40);

      repeat (3) tick();
      checkOutput("i_done_count", 32'(iDoneSeen), 32'(iDoneExpect));
      checkOutput("d_done_count", 32'(dDoneSeen), 32'(dDoneExpect));
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
